vga_timing: RTL and testbench

VGA_TIMING -- requirements
Module: vga_timing

---
 rtl/vga_pkg.sv | 37 +++
 rtl/step_ticker.sv | 48 ++++
 rtl/vga_timing.sv | 98 +++++++++
 tb/tb_vga_timing.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants and the registered pixel-output bundle.
// Also used by the pixel renderer.
package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int CNT_W  = 10;
  localparam int FCNT_W = 6;

  typedef struct packed {
    logic             hsync;
    logic             vsync;
    logic             video_on;
    logic             frame_start;
    logic [CNT_W-1:0] pix_x;
    logic [CNT_W-1:0] pix_y;
  } vga_pix_t;

  localparam vga_pix_t VGA_PIX_RST = '{hsync: 1'b1, vsync: 1'b1, default: '0};

  function automatic logic in_win(input logic [CNT_W-1:0] v,
                                  input logic [CNT_W-1:0] lo,
                                  input logic [CNT_W-1:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/step_ticker.sv
// Game-step strobe: counts frame_start pulses and fires once every max(step_div,1) frames.
// Registered so step_tick lines up with the registered frame_start of the timing core.
module step_ticker
  import vga_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic [FCNT_W-1:0] step_div,
  input  logic              pause,
  output logic              step_tick
);

  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic [FCNT_W-1:0] div_eff;
  logic [FCNT_W:0]   fcnt_inc;
  logic              tick_d, tick_q;

  assign div_eff  = (step_div == '0) ? FCNT_W'(1) : step_div;
  assign fcnt_inc = {1'b0, fcnt_q} + (FCNT_W+1)'(1);

  // >= rather than == so lowering step_div below fcnt fires on the next frame
  always_comb begin
    fcnt_d = fcnt_q;
    tick_d = 1'b0;
    if (frame_start && !pause) begin
      if (fcnt_inc >= {1'b0, div_eff}) begin
        tick_d = 1'b1;
        fcnt_d = '0;
      end else begin
        fcnt_d = fcnt_inc[FCNT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q <= '0;
      tick_q <= 1'b0;
    end else begin
      fcnt_q <= fcnt_d;
      tick_q <= tick_d;
    end
  end

  assign step_tick = tick_q;

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing: h/v counters with registered sync/blank/position outputs.
// Optional game-step strobe built only when VGA_STEP_TICK_EN is defined.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FCNT_W-1:0] step_div,
  input  logic              pause,
  output logic              hsync,
  output logic              vsync,
  output logic              video_on,
  output logic [CNT_W-1:0]  pix_x,
  output logic [CNT_W-1:0]  pix_y,
  output logic              frame_start,
  output logic              step_tick
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  // Counters point at the pixel to be presented on the next edge, so the
  // first edge after reset release presents (0,0).
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic             h_wrap;
  vga_pix_t         pix_q, pix_d;

  always_comb begin
    h_wrap  = (h_cnt_q == H_LAST);
    h_cnt_d = h_wrap ? '0 : h_cnt_q + CNT_W'(1);
    v_cnt_d = v_cnt_q;
    if (h_wrap) v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CNT_W'(1);
  end

  always_comb begin
    pix_d             = VGA_PIX_RST;
    pix_d.hsync       = !in_win(h_cnt_q, HS_BEG, HS_END);
    pix_d.vsync       = !in_win(v_cnt_q, VS_BEG, VS_END);
    pix_d.video_on    = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    pix_d.frame_start = (h_cnt_q == '0) && (v_cnt_q == '0);
    pix_d.pix_x       = h_cnt_q;
    pix_d.pix_y       = v_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      pix_q   <= VGA_PIX_RST;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      pix_q   <= pix_d;
    end
  end

  assign hsync       = pix_q.hsync;
  assign vsync       = pix_q.vsync;
  assign video_on    = pix_q.video_on;
  assign frame_start = pix_q.frame_start;
  assign pix_x       = pix_q.pix_x;
  assign pix_y       = pix_q.pix_y;

`ifdef VGA_STEP_TICK_EN
  // Fed the pre-register strobe so its registered tick coincides with frame_start.
  step_ticker u_step (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (pix_d.frame_start),
    .step_div    (step_div),
    .pause       (pause),
    .step_tick   (step_tick)
  );
`else
  logic unused_step_in;
  assign unused_step_in = ^{step_div, pause};
  assign step_tick      = 1'b0;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Checks a default-geometry and a tiny-geometry vga_timing against a pixel-index model.
module tb_vga_timing;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] step_div;
  logic       pause;

  logic       hs[2], vs[2], vo[2], fs[2], st[2];
  logic [9:0] px[2], py[2];

  localparam int HA[2] = '{640, 8};
  localparam int HF[2] = '{16,  2};
  localparam int HS[2] = '{96,  3};
  localparam int HB[2] = '{48,  2};
  localparam int VA[2] = '{480, 4};
  localparam int VF[2] = '{10,  1};
  localparam int VS[2] = '{2,   2};
  localparam int VB[2] = '{33,  1};

  vga_timing u_def (
    .clk(clk), .rst_n(rst_n), .step_div(step_div), .pause(pause),
    .hsync(hs[0]), .vsync(vs[0]), .video_on(vo[0]), .pix_x(px[0]), .pix_y(py[0]),
    .frame_start(fs[0]), .step_tick(st[0])
  );

  vga_timing #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .step_div(step_div), .pause(pause),
    .hsync(hs[1]), .vsync(vs[1]), .video_on(vo[1]), .pix_x(px[1]), .pix_y(py[1]),
    .frame_start(fs[1]), .step_tick(st[1])
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n      = 0;      // pixels presented since reset release (0 = in reset)
  int fcnt[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s @n=%0d: got %0d expected %0d", tag, n, obs, exp);
    end
  endtask

  // Expected outputs derived from the linear pixel index n-1 within a frame.
  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      int   ht, vt, p, x, y;
      logic ehs, evs, evo, efs, est;
      ehs = 1'b1; evs = 1'b1; evo = 1'b0; efs = 1'b0; est = 1'b0; x = 0; y = 0;
      if (n > 0) begin
        ht  = HA[i] + HF[i] + HS[i] + HB[i];
        vt  = VA[i] + VF[i] + VS[i] + VB[i];
        p   = (n - 1) % (ht * vt);
        x   = p % ht;
        y   = p / ht;
        ehs = !(x >= HA[i] + HF[i] && x < HA[i] + HF[i] + HS[i]);
        evs = !(y >= VA[i] + VF[i] && y < VA[i] + VF[i] + VS[i]);
        evo = (x < HA[i]) && (y < VA[i]);
        efs = (p == 0);
`ifdef VGA_STEP_TICK_EN
        if (efs && !pause) begin
          if (fcnt[i] + 1 >= ((step_div == 0) ? 1 : int'(step_div))) begin
            est     = 1'b1;
            fcnt[i] = 0;
          end else begin
            fcnt[i]++;
          end
        end
`endif
      end
      chk($sformatf("u%0d.hsync", i),       32'(hs[i]), 32'(ehs));
      chk($sformatf("u%0d.vsync", i),       32'(vs[i]), 32'(evs));
      chk($sformatf("u%0d.video_on", i),    32'(vo[i]), 32'(evo));
      chk($sformatf("u%0d.frame_start", i), 32'(fs[i]), 32'(efs));
      chk($sformatf("u%0d.step_tick", i),   32'(st[i]), 32'(est));
      chk($sformatf("u%0d.pix_x", i),       32'(px[i]), 32'(x));
      chk($sformatf("u%0d.pix_y", i),       32'(py[i]), 32'(y));
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst_n) n++;
    #1;
    check_all();
  endtask

  task automatic run_to(input int target);
    int guard = 0;
    while (n < target && guard < 20000) begin
      cyc();
      guard++;
    end
    chk("run_to_reached", 32'(n), 32'(target));
  endtask

  // Asynchronous assertion mid-cycle: outputs must drop to reset values at once.
  task automatic assert_rst();
    rst_n = 1'b0;
    #1;
    n = 0;
    fcnt[0] = 0;
    fcnt[1] = 0;
    check_all();
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    step_div = 6'd3;
    pause    = 1'b0;
    fcnt[0]  = 0;
    fcnt[1]  = 0;
    rst_n    = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) cyc();

    // Release: pixel (0,0) with frame_start on the first edge; step_div=3 ticks frames 3,6,9
    release_rst();
    run_to(1);
    run_to(1501);                    // default geometry at x=700, y=1
    assert_rst();

    // Pause held over small frames 4..7 (frame k starts at n=(k-1)*120+1)
    release_rst();
    run_to(300);
    pause = 1'b1;
    run_to(800);
    pause = 1'b0;
    run_to(1300);
    run_to(1364);                    // small geometry at x=13 (back porch), y=2
    assert_rst();

    // step_div=0 behaves as 1: tick every frame
    release_rst();
    step_div = 6'd0;
    run_to(602);

    // Lower step_div below the running count: tick on the next frame
    step_div = 6'd5;
    run_to(1100);
    step_div = 6'd2;
    run_to(1300);

    // Randomized divisors and pause, per small frame
    for (int k = 0; k < 20; k++) begin
      step_div = 6'($urandom_range(0, 6));
      pause    = ($urandom_range(0, 3) == 0);
      run_to(n + 120);
    end
    pause = 1'b0;
    run_to(n + int'($urandom_range(1, 200)));
    assert_rst();
    step_div = 6'($urandom_range(0, 63));
    release_rst();
    run_to(400);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
